// File: rtl/addsub_serial_sat_pkg.sv
`default_nettype none
// ============================================================================
// Module      : addsub_pkg
// Description : Shared types and constants for the serial saturating
//               add/subtract unit (FSM state type, default geometry,
//               saturation limits).
// Revision    : 1.0  initial release
// ============================================================================
package addsub_pkg;

    // Two-state control: idle waiting for start, or stepping through slices.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } addsub_state_t;

    localparam int WIDTH  = 16;
    localparam int SLICE  = 4;
    localparam int NSLICE = WIDTH / SLICE;

    localparam logic [15:0] SAT_POS = 16'h7FFF;
    localparam logic [15:0] SAT_NEG = 16'h8000;

endpackage : addsub_pkg
`default_nettype wire

// File: rtl/addsub_serial_sat_if.sv
`default_nettype none
// ============================================================================
// Module      : addsub_serial_sat_if
// Description : Request/response bundle for addsub_serial_sat.
//               master : drives start/sub/a/b, observes busy/done/result/flags
//               slave  : the arithmetic unit side
// Ports       : start, sub, a[WIDTH], b[WIDTH]        (master -> slave)
//               busy, done, result[WIDTH], ovfl, zero, neg (slave -> master)
// Revision    : 1.0  initial release
// ============================================================================
interface addsub_serial_sat_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             ovfl;
    logic             zero;
    logic             neg;

    modport master (
        output start, sub, a, b,
        input  busy, done, result, ovfl, zero, neg
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, result, ovfl, zero, neg
    );

endinterface : addsub_serial_sat_if
`default_nettype wire

// File: rtl/addsub_serial_sat_cla4.sv
`default_nettype none
// ============================================================================
// Module      : nibble_cla4
// Description : Combinational 4-bit carry-lookahead adder slice.
// Ports       : a[3:0], b[3:0], cin  -> sum[3:0], cout,
//               p (group propagate), g (group generate)
// Revision    : 1.0  initial release
// ============================================================================
module nibble_cla4 (
    input  wire logic [3:0] a,
    input  wire logic [3:0] b,
    input  wire logic       cin,
    output logic      [3:0] sum,
    output logic            cout,
    output logic            p,
    output logic            g
);
    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [4:0] w_c;

    assign w_p = a ^ b;
    assign w_g = a & b;

    // Every carry is expanded directly from cin so no ripple chain forms.
    assign w_c[0] = cin;
    assign w_c[1] = w_g[0] | (w_p[0] & cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & cin);

    assign g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
             | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign p = &w_p;

    assign w_c[4] = g | (p & cin);

    assign sum  = w_p ^ w_c[3:0];
    assign cout = w_c[4];

endmodule : nibble_cla4
`default_nettype wire

// File: rtl/addsub_serial_sat.sv
`default_nettype none
// ============================================================================
// Module      : addsub_serial_sat
// Description : Multi-cycle saturating add/subtract. One SLICE-bit slice of
//               A + B' (B' = B or ~B with carry-in 1) is computed per clock
//               through a single nibble_cla4; after the last slice the
//               result is optionally clamped and N/Z/V flags are registered.
// Ports       : clk        rising-edge clock
//               rst        asynchronous active-high reset
//               bus.slave  start/sub/a/b in; busy/done/result/ovfl/zero/neg out
// Parameters  : WIDTH (multiple of SLICE, at least 2 slices), SLICE (must be 4,
//               the width of the CLA slice), SATURATE (1 clamp, 0 wrap)
// Revision    : 1.0  initial release
// ============================================================================
module addsub_serial_sat
    import addsub_pkg::*;
#(
    parameter int WIDTH    = addsub_pkg::WIDTH,
    parameter int SLICE    = addsub_pkg::SLICE,
    parameter int SATURATE = 1
) (
    input  wire logic         clk,
    input  wire logic         rst,
    addsub_serial_sat_if.slave bus
);
    localparam int c_NSLICE = WIDTH / SLICE;
    localparam int c_CNT_W  = (c_NSLICE > 1) ? $clog2(c_NSLICE) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_NSLICE - 1);
    localparam logic [WIDTH-1:0] c_SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    addsub_state_t      r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_a;        // operand A, shifted right one slice per step
    logic [WIDTH-1:0]   r_b;        // operand B' (already inverted for subtract)
    logic [WIDTH-1:0]   r_part;     // partial sum, filled from the top
    logic               r_a_msb;    // sign of A, kept because r_a shifts away
    logic               r_b_msb;    // sign of B'
    logic               r_carry;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_result;
    logic               r_ovfl;
    logic               r_zero;
    logic               r_neg;

    logic [SLICE-1:0]   w_sum_sl;
    logic               w_cout;
    logic               w_grp_p;
    logic               w_grp_g;
    logic [WIDTH-1:0]   w_sum_full;
    logic               w_ovfl;
    logic [WIDTH-1:0]   w_final;
    logic               w_unused_pg;

    // The single shared slice always sees the low slice of the shifting
    // operand registers, so no wide slice-select mux is needed.
    nibble_cla4 u_cla (
        .a    (r_a[SLICE-1:0]),
        .b    (r_b[SLICE-1:0]),
        .cin  (r_carry),
        .sum  (w_sum_sl),
        .cout (w_cout),
        .p    (w_grp_p),
        .g    (w_grp_g)
    );

    // Group propagate/generate are only needed when slices are chained
    // by lookahead; here the carry is registered between slices instead.
    assign w_unused_pg = w_grp_p ^ w_grp_g;

    // On the final slice the earlier slices sit in r_part[WIDTH-1:SLICE];
    // prepending the current slice yields the full raw sum.
    assign w_sum_full = {w_sum_sl, r_part[WIDTH-1:SLICE]};
    assign w_ovfl     = (r_a_msb == r_b_msb) && (w_sum_full[WIDTH-1] != r_a_msb);
    assign w_final    = ((SATURATE != 0) && w_ovfl)
                      ? (r_a_msb ? c_SAT_NEG : c_SAT_POS)
                      : w_sum_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_part   <= '0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_carry  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_ovfl   <= 1'b0;
            r_zero   <= 1'b0;
            r_neg    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b ^ {WIDTH{bus.sub}};
                        r_a_msb <= bus.a[WIDTH-1];
                        r_b_msb <= bus.b[WIDTH-1] ^ bus.sub;
                        r_carry <= bus.sub;   // +1 completes the two's complement
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> SLICE;
                    r_b     <= r_b >> SLICE;
                    r_part  <= w_sum_full;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + c_CNT_W'(1);
                    if (r_cnt == c_LAST) begin
                        r_result <= w_final;
                        r_ovfl   <= w_ovfl;
                        r_zero   <= (w_final == '0);
                        r_neg    <= w_final[WIDTH-1];
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.ovfl   = r_ovfl;
    assign bus.zero   = r_zero;
    assign bus.neg    = r_neg;

endmodule : addsub_serial_sat
`default_nettype wire

// File: tb/tb_addsub_serial_sat.sv
`default_nettype none
// ============================================================================
// Module      : tb_addsub_serial_sat
// Description : Self-checking bench for addsub_serial_sat. Drives one
//               saturating and one wrapping instance with identical stimulus;
//               directed vector table, hand-written timing sequences and
//               randomized operations against an integer-arithmetic model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_addsub_serial_sat;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    addsub_serial_sat_if #(.WIDTH(16)) u_if_sat ();
    addsub_serial_sat_if #(.WIDTH(16)) u_if_wrap ();

    assign u_if_wrap.start = u_if_sat.start;
    assign u_if_wrap.sub   = u_if_sat.sub;
    assign u_if_wrap.a     = u_if_sat.a;
    assign u_if_wrap.b     = u_if_sat.b;

    addsub_serial_sat #(.WIDTH(16), .SLICE(4), .SATURATE(1)) u_dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (u_if_sat.slave)
    );

    addsub_serial_sat #(.WIDTH(16), .SLICE(4), .SATURATE(0)) u_dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (u_if_wrap.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] exp_sat;
        logic [15:0] exp_wrap;
        logic        exp_v;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: exact integer arithmetic, then range check decides overflow.
    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  input logic sub, input bit sat,
                                  output logic [15:0] res, output logic v);
        int sa, sb, r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        r  = sub ? (sa - sb) : (sa + sb);
        v  = (r > 32767) || (r < -32768);
        if (sat && r > 32767)       res = 16'h7FFF;
        else if (sat && r < -32768) res = 16'h8000;
        else                        res = r[15:0];
    endfunction

    // Called #1 after a clock edge; returns #1 after the done edge, so a
    // following call issues its start in the done cycle (back-to-back).
    task automatic run_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                          input logic sub, input logic [15:0] exp_sat,
                          input logic [15:0] exp_wrap, input logic exp_v);
        int cyc;
        int busy_n;
        u_if_sat.a     = a;
        u_if_sat.b     = b;
        u_if_sat.sub   = sub;
        u_if_sat.start = 1'b1;
        @(posedge clk); #1;
        u_if_sat.start = 1'b0;
        check({nm, "/done_low_first"}, u_if_sat.done, 1'b0);
        cyc    = 0;
        busy_n = 0;
        while (!u_if_sat.done && cyc < 20) begin
            if (u_if_sat.busy) busy_n++;
            @(posedge clk); #1;
            cyc++;
        end
        check({nm, "/latency"},   cyc, 4);
        check({nm, "/busy_cyc"},  busy_n, 4);
        check({nm, "/busy_done"}, u_if_sat.busy, 1'b0);
        check({nm, "/sat_res"},   u_if_sat.result, exp_sat);
        check({nm, "/sat_v"},     u_if_sat.ovfl, exp_v);
        check({nm, "/sat_z"},     u_if_sat.zero, (exp_sat == 16'h0000));
        check({nm, "/sat_n"},     u_if_sat.neg, exp_sat[15]);
        check({nm, "/wrap_done"}, u_if_wrap.done, 1'b1);
        check({nm, "/wrap_res"},  u_if_wrap.result, exp_wrap);
        check({nm, "/wrap_v"},    u_if_wrap.ovfl, exp_v);
        check({nm, "/wrap_n"},    u_if_wrap.neg, exp_wrap[15]);
    endtask

    initial begin
        int n_done;
        logic [15:0] cap;
        logic [15:0] ra, rb, es, ew;
        logic rs, ev, evw;
        logic [15:0] specials[6];

        specials[0] = 16'h0000; specials[1] = 16'h0001; specials[2] = 16'h7FFF;
        specials[3] = 16'h8000; specials[4] = 16'hFFFF; specials[5] = 16'h8001;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 16'h5555, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 16'h8000, 1'b1};
        vecs[2] = '{16'h8000, 16'h0001, 1'b1, 16'h8000, 16'h7FFF, 1'b1};
        vecs[3] = '{16'h0005, 16'h0005, 1'b1, 16'h0000, 16'h0000, 1'b0};
        vecs[4] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h8000, 16'h0000, 1'b1};
        vecs[6] = '{16'h0000, 16'h8000, 1'b1, 16'h7FFF, 16'h8000, 1'b1};
        vecs[7] = '{16'hFFFF, 16'h8000, 1'b1, 16'h7FFF, 16'h7FFF, 1'b0};

        rst            = 1'b1;
        u_if_sat.start = 1'b0;
        u_if_sat.sub   = 1'b0;
        u_if_sat.a     = '0;
        u_if_sat.b     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset/busy",   u_if_sat.busy, 1'b0);
        check("reset/done",   u_if_sat.done, 1'b0);
        check("reset/result", u_if_sat.result, 16'h0000);
        check("reset/flags",  {u_if_sat.ovfl, u_if_sat.zero, u_if_sat.neg}, 3'b000);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub,
                   vecs[i].exp_sat, vecs[i].exp_wrap, vecs[i].exp_v);
            @(posedge clk); #1;
            check($sformatf("vec%0d/done_drop", i), u_if_sat.done, 1'b0);
            check($sformatf("vec%0d/hold", i), u_if_sat.result, vecs[i].exp_sat);
        end

        // Start while busy must be ignored: one done, first operands only.
        u_if_sat.a = 16'h1234; u_if_sat.b = 16'h1111; u_if_sat.sub = 1'b0;
        u_if_sat.start = 1'b1;
        @(posedge clk); #1;
        u_if_sat.start = 1'b0;
        @(posedge clk); #1;
        u_if_sat.a = 16'h7000; u_if_sat.b = 16'h0FFF; u_if_sat.sub = 1'b1;
        u_if_sat.start = 1'b1;
        @(posedge clk); #1;
        u_if_sat.start = 1'b0;
        n_done = 0;
        cap    = 16'hDEAD;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (u_if_sat.done) begin
                n_done++;
                cap = u_if_sat.result;
            end
        end
        check("ignore/n_done", n_done, 1);
        check("ignore/result", cap, 16'h2345);

        // Reset on the third RUN cycle abandons the operation.
        run_op("pre_rst", 16'h1234, 16'h4321, 1'b0, 16'h5555, 16'h5555, 1'b0);
        u_if_sat.a = 16'h7FFF; u_if_sat.b = 16'h0001; u_if_sat.sub = 1'b0;
        u_if_sat.start = 1'b1;
        @(posedge clk); #1;
        u_if_sat.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst/busy",   u_if_sat.busy, 1'b0);
        check("midrst/done",   u_if_sat.done, 1'b0);
        check("midrst/result", u_if_sat.result, 16'h0000);
        check("midrst/flags",  {u_if_sat.ovfl, u_if_sat.zero, u_if_sat.neg}, 3'b000);
        @(posedge clk); #1;
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (u_if_sat.done) n_done++;
        end
        check("midrst/no_done", n_done, 0);
        run_op("b2b_first",  16'h0001, 16'h0001, 1'b0, 16'h0002, 16'h0002, 1'b0);
        run_op("b2b_second", 16'h0003, 16'h0004, 1'b0, 16'h0007, 16'h0007, 1'b0);

        // Randomized operations against the integer model.
        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : 16'($urandom);
            rs = 1'($urandom_range(0, 1));
            model(ra, rb, rs, 1'b1, es, ev);
            model(ra, rb, rs, 1'b0, ew, evw);
            run_op($sformatf("rnd%0d_%h_%h_%0d", i, ra, rb, rs), ra, rb, rs, es, ew, ev);
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk); #1;
                check($sformatf("rnd%0d/done_drop", i), u_if_sat.done, 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_addsub_serial_sat
`default_nettype wire
